adder_tree_accumulator: RTL and testbench

//  Pipelined, signed reduction of the KERNEL_SIZE**2 Q8.8 products from the

---
 rtl/adder_tree_accumulator_if.sv | 32 +++
 rtl/adder_tree_accumulator.sv | 134 +++++++++++++
 tb/tb_adder_tree_accumulator.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/adder_tree_accumulator_if.sv
// Bus between the multiplier stage and the adder tree: one product vector in,
// one saturated pixel sum out. There is no backpressure in either direction.
interface adder_tree_accumulator_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5
);
  localparam int N = KERNEL_SIZE * KERNEL_SIZE;

  logic [N*DATA_WIDTH-1:0] products;
  logic                    valid_in;
  logic [DATA_WIDTH-1:0]   sum;
  logic                    valid_out;
  logic                    saturated;

  // Producer side: drives the product vector and observes the result
  modport master (
    output products,
    output valid_in,
    input  sum,
    input  valid_out,
    input  saturated
  );

  // Adder tree side
  modport slave (
    input  products,
    input  valid_in,
    output sum,
    output valid_out,
    output saturated
  );
endinterface

// File: rtl/adder_tree_accumulator.sv
// Pipelined signed reduction of KERNEL_SIZE**2 Q8.8 products into one pixel.
// Each tree level is one register stage and is one bit wider than the level
// before it, so no internal overflow is possible. The final pair is added in
// the output stage, where the total is clipped to signed DATA_WIDTH.
// Latency from valid_in to valid_out is $clog2(N)+1 cycles.
module adder_tree_accumulator #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5
) (
  input logic                     clk,
  input logic                     rst_n,
  adder_tree_accumulator_if.slave bus
);
  localparam int N      = KERNEL_SIZE * KERNEL_SIZE;
  localparam int LEVELS = $clog2(N);
  localparam int TW     = DATA_WIDTH + LEVELS + 1;

  // Limits of signed DATA_WIDTH, written out at the width of the full total
  localparam logic signed [TW-1:0] SAT_MAX =
    {{(TW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [TW-1:0] SAT_MIN =
    {{(TW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Number of elements held at tree level k (ceil-halving from N)
  function automatic int level_count(input int k);
    int c;
    c = N;
    for (int i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Tree levels 0..LEVELS-1. Level k holds level_count(k) elements of
  // DATA_WIDTH+k+1 bits.
  for (genvar gk = 0; gk < LEVELS; gk++) begin : g_lvl
    localparam int CNT = level_count(gk);
    localparam int WID = DATA_WIDTH + gk + 1;

    for (genvar gi = 0; gi < CNT; gi++) begin : g_el
      logic signed [WID-1:0] el_d;
      logic signed [WID-1:0] el_q;
      logic                  el_en;

      if (gk == 0) begin : g_leaf
        logic [DATA_WIDTH-1:0] prod;
        assign prod  = bus.products[gi*DATA_WIDTH +: DATA_WIDTH];
        assign el_d  = {prod[DATA_WIDTH-1], prod};
        // Product vectors are captured only when they are flagged valid
        assign el_en = bus.valid_in;
      end else begin : g_node
        localparam int PCNT = level_count(gk - 1);
        logic signed [WID-2:0] lhs;
        assign lhs   = g_lvl[gk-1].g_el[2*gi].el_q;
        assign el_en = 1'b1;
        if (2*gi + 1 < PCNT) begin : g_pair
          logic signed [WID-2:0] rhs;
          assign rhs  = g_lvl[gk-1].g_el[2*gi+1].el_q;
          assign el_d = {lhs[WID-2], lhs} + {rhs[WID-2], rhs};
        end else begin : g_odd
          // Odd leftover moves up a level unchanged, only sign-extended
          assign el_d = {lhs[WID-2], lhs};
        end
      end

      // Tree element register; reset clears any in-flight data
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          el_q <= '0;
        end else if (el_en) begin
          el_q <= el_d;
        end
      end
    end
  end

  // Valid travels alongside the data, one bit per tree level
  logic [LEVELS-1:0] valid_q;
  logic [LEVELS-1:0] valid_d;
  assign valid_d = {valid_q[LEVELS-2:0], bus.valid_in};

  // Valid shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // The last tree level always holds exactly two elements
  logic signed [TW-2:0]     fin_a;
  logic signed [TW-2:0]     fin_b;
  logic signed [TW-1:0]     total;
  logic [DATA_WIDTH-1:0]    sum_d;
  logic                     saturated_d;
  logic                     valid_out_d;
  logic [DATA_WIDTH-1:0]    sum_q;
  logic                     saturated_q;
  logic                     valid_out_q;

  assign fin_a = g_lvl[LEVELS-1].g_el[0].el_q;
  assign fin_b = g_lvl[LEVELS-1].g_el[1].el_q;

  // Final add and clip to signed DATA_WIDTH; exact range limits pass through
  always_comb begin
    total       = {fin_a[TW-2], fin_a} + {fin_b[TW-2], fin_b};
    sum_d       = total[DATA_WIDTH-1:0];
    saturated_d = 1'b0;
    valid_out_d = valid_q[LEVELS-1];
    if (total > SAT_MAX) begin
      sum_d       = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      saturated_d = valid_q[LEVELS-1];
    end else if (total < SAT_MIN) begin
      sum_d       = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      saturated_d = valid_q[LEVELS-1];
    end
  end

  // Output register; saturated is forced low on non-valid cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      saturated_q <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      saturated_q <= saturated_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.saturated = saturated_q;
  assign bus.valid_out = valid_out_q;
endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Self-checking bench for adder_tree_accumulator: table of directed vectors,
// a mid-stream reset sequence and random traffic, all scored through a queue.
module tb_adder_tree_accumulator;
  localparam int W   = 16;
  localparam int K   = 5;
  localparam int N   = K * K;
  localparam int LAT = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  adder_tree_accumulator_if #(.DATA_WIDTH(W), .KERNEL_SIZE(K)) bus_if ();

  adder_tree_accumulator #(.DATA_WIDTH(W), .KERNEL_SIZE(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         sat;
    int           cyc;
    int           id;
  } exp_t;

  typedef struct {
    logic [W-1:0] base;
    int           ia;
    logic [W-1:0] va;
    int           ib;
    logic [W-1:0] vb;
    logic [W-1:0] es;
    logic         esat;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[12];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   next_id  = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s (id %0d): got %0h, required %0h", name, id, act, req);
  endtask

  // Independent reference: 32-bit signed sum, then clip to 16 bits
  function automatic logic [W:0] ref_model(input logic [N*W-1:0] p);
    int s;
    logic [W-1:0] v;
    s = 0;
    for (int j = 0; j < N; j++) begin
      v = p[j*W +: W];
      s += int'($signed(v));
    end
    if (s > 32767)  return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, s[15:0]};
  endfunction

  // Drive one cycle of stimulus; valid vectors are scored when pushed is set
  task automatic drive(input logic [N*W-1:0] p, input logic v, input logic push,
                       input logic [W-1:0] es, input logic esat);
    bus_if.products = p;
    bus_if.valid_in = v;
    if (v && push) begin
      sb_q.push_back('{sum: es, sat: esat, cyc: cyc + LAT, id: next_id});
      next_id++;
    end
  endtask

  // Monitor: compare each valid_out against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus_if.valid_out) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid_out", -1, 32'(bus_if.valid_out), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sum", e.id, 32'(bus_if.sum), 32'(e.sum));
          check("saturated", e.id, 32'(bus_if.saturated), 32'(e.sat));
          check("latency_cycle", e.id, 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check("idle_saturated", -1, 32'(bus_if.saturated), 32'd0);
      end
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 4 * LAT) begin
      @(negedge clk);
      drive('0, 1'b0, 1'b0, '0, 1'b0);
      guard++;
    end
    check("drain_pending", -1, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic [N*W-1:0] p;
    logic [W:0]     r;
    logic           v;
    int             mode;
    int             val;
    int             vo_cnt;

    tbl[0]  = '{16'h0100, -1, 16'h0000, -1, 16'h0000, 16'h1900, 1'b0};
    tbl[1]  = '{16'h0000,  0, 16'h0100, 24, 16'hFF00, 16'h0000, 1'b0};
    tbl[2]  = '{16'h7FFF, -1, 16'h0000, -1, 16'h0000, 16'h7FFF, 1'b1};
    tbl[3]  = '{16'h8000, -1, 16'h0000, -1, 16'h0000, 16'h8000, 1'b1};
    tbl[4]  = '{16'h0010, -1, 16'h0000, -1, 16'h0000, 16'h0190, 1'b0};
    tbl[5]  = '{16'h0020, -1, 16'h0000, -1, 16'h0000, 16'h0320, 1'b0};
    tbl[6]  = '{16'hFFF0, -1, 16'h0000, -1, 16'h0000, 16'hFE70, 1'b0};
    tbl[7]  = '{16'h0000,  0, 16'h7FFF, -1, 16'h0000, 16'h7FFF, 1'b0};
    tbl[8]  = '{16'h0000,  0, 16'h8000, -1, 16'h0000, 16'h8000, 1'b0};
    tbl[9]  = '{16'h0000,  0, 16'h7FFF,  1, 16'h0001, 16'h7FFF, 1'b1};
    tbl[10] = '{16'h0000,  0, 16'h8000,  1, 16'hFFFF, 16'h8000, 1'b1};
    tbl[11] = '{16'h051F, -1, 16'h0000, -1, 16'h0000, 16'h7FFF, 1'b1};

    bus_if.products = '0;
    bus_if.valid_in = 1'b0;

    // Power-on reset
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sum", -1, 32'(bus_if.sum), 32'd0);
    check("reset_valid_out", -1, 32'(bus_if.valid_out), 32'd0);
    check("reset_saturated", -1, 32'(bus_if.saturated), 32'd0);
    rst_n = 1'b1;

    // Directed table, applied back-to-back
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      for (int j = 0; j < N; j++) p[j*W +: W] = tbl[i].base;
      if (tbl[i].ia >= 0) p[tbl[i].ia*W +: W] = tbl[i].va;
      if (tbl[i].ib >= 0) p[tbl[i].ib*W +: W] = tbl[i].vb;
      drive(p, 1'b1, 1'b1, tbl[i].es, tbl[i].esat);
    end
    drain();

    // Mid-stream reset: a vector in flight must be discarded
    @(negedge clk);
    for (int j = 0; j < N; j++) p[j*W +: W] = 16'h0100;
    drive(p, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    drive('0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_sum", -1, 32'(bus_if.sum), 32'd0);
    check("midrst_valid_out", -1, 32'(bus_if.valid_out), 32'd0);
    check("midrst_saturated", -1, 32'(bus_if.saturated), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vo_cnt = 0;
    repeat (3 * LAT) begin
      @(negedge clk);
      if (bus_if.valid_out) vo_cnt++;
    end
    check("midrst_discarded", -1, 32'(vo_cnt), 32'd0);

    // First vector after reset must appear exactly LAT cycles later
    @(negedge clk);
    for (int j = 0; j < N; j++) p[j*W +: W] = 16'h0020;
    drive(p, 1'b1, 1'b1, 16'h0320, 1'b0);
    @(negedge clk);
    drive('0, 1'b0, 1'b0, '0, 1'b0);
    drain();

    // Random traffic with random gaps
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      v    = ($urandom_range(0, 9) < 7);
      mode = int'($urandom_range(0, 2));
      for (int j = 0; j < N; j++) begin
        if (mode == 0)      val = int'($urandom_range(0, 65535));
        else if (mode == 1) val = int'($urandom_range(0, 4095)) - 2048;
        else                val = 1310 + int'($urandom_range(0, 40)) - 20;
        p[j*W +: W] = val[15:0];
      end
      r = ref_model(p);
      drive(p, v, 1'b1, r[W-1:0], r[W]);
    end
    @(negedge clk);
    drive('0, 1'b0, 1'b0, '0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
